serial_pixel_loader: RTL and testbench
======================================

// Module: serial_pixel_loader
// PURPOSE
//   Receive end of the GAN bit-serial pixel interface: accepts 1-bit pixels via valid/ready,
//   expands each to a Q8.8 word and assembles one PIXEL_COUNT frame for the generator/disc
//   pipeline. Raises frame_ready when the frame is complete. Holds it until the consumer's
//   start pulse; frame_ready is what the upstream streamer waits on before firing start.
// PARAMETERS
//   PIXEL_COUNT  784       pixels per frame (28x28)
//   ONE_WORD     16'h0100  Q8.8 word stored for pixel_bit=1 (+1.0)
//   ZERO_WORD    16'h0000  Q8.8 word stored for pixel_bit=0 (0.0)
//   CW           $clog2(PIXEL_COUNT+1)  (localparam) counter width, 10 for 784
// PORTS
//   clk              in   1               clock, rising edge
//   rst              in   1               reset, asynchronous, active-high
//   pixel_bit        in   1               serial pixel value
//   pixel_bit_valid  in   1               pixel_bit is valid this cycle
//   pixel_bit_ready  out  1               loader accepts a pixel this cycle
//   frame_consume    in   1               1-cycle pulse: consumer took the frame (GAN start)
//   abort            in   1               sync clear of the partial or complete frame
//   frame_ready      out  1               full frame held in frame_flat
//   frame_flat       out  16*PIXEL_COUNT  pixel i at [16*i+15:16*i]; first received = i=0
//   pixel_count      out  CW              pixels accepted into the current frame
//   ones_count       out  CW              accepted pixels with bit=1 in the current frame
// BEHAVIOUR
//   Reset: state=LOAD, frame_ready=0, pixel_count=0, ones_count=0, frame_flat all zero.
//     pixel_bit_ready=0 while rst is high.
//   States: LOAD (collecting) and FULL (frame held).
//   pixel_bit_ready = (state==LOAD) & ~rst. Decoded from state only, never from valid.
//     Valid may be high before ready, and may drop without a transfer.
//   Transfer = pixel_bit_valid & pixel_bit_ready, sampled on posedge clk.
//     On a transfer:
//       word[pixel_count] <= bit ? ONE_WORD : ZERO_WORD, visible on frame_flat next cycle
//       pixel_count++
//       ones_count += bit
//   Last pixel: transfer while pixel_count==PIXEL_COUNT-1.
//     Next cycle: state=FULL, frame_ready=1, pixel_count=PIXEL_COUNT, pixel_bit_ready=0.
//     Latency from last transfer to frame_ready is 1 clk.
//   FULL: frame_flat, pixel_count and ones_count are frozen. valid is ignored (no transfer).
//   frame_consume in FULL: next cycle frame_ready=0, state=LOAD, pixel_count=0,
//     ones_count=0. frame_flat is kept; words are overwritten only as new pixels arrive.
//   frame_consume in LOAD: ignored, no effect on counters or data.
//   abort (any state): next cycle state=LOAD, frame_ready=0, counters=0, frame_flat kept.
//     abort wins over a same-cycle transfer (that pixel is dropped) and over frame_consume.
//   frame_consume and the final transfer in the same cycle: consume is ignored, since state
//     is still LOAD. The frame goes FULL normally.
//   Index never wraps. No write occurs at index >= PIXEL_COUNT.
//   ones_count <= pixel_count always.
//   rst asserted mid-frame: immediate asynchronous return to reset values, partial frame lost.
// STRUCTURE
//   Shared package gan_pkg:
//     Q88_ONE=16'h0100, Q88_ZERO=16'h0000
//     GAN_PIXEL_COUNT=784
//     loader state encoding (LOAD=1'b0, FULL=1'b1)
//   Single flat module: 2-state FSM, index counter, ones counter, word-write decode into
//     the frame register. No sub-module is warranted; the expansion mux is one line.
// TESTING
//   1 Reset, then valid=1 held for 784 cycles with bits alternating 1,0,...
//     -> word0=0x0100, word1=0x0000; frame_ready=1 exactly 1 clk after 784th transfer;
//        ones_count=392, pixel_count=784.
//   2 FULL, valid=1 held 10 more cycles
//     -> ready=0 throughout; frame_flat and counters unchanged.
//   3 Random valid gaps (~30% idle), all bits=1
//     -> exactly 784 transfers; ones_count=784; every word=0x0100; no extra write.
//   4 frame_consume pulse in FULL
//     -> next clk frame_ready=0, ready=1, counters=0, old frame_flat intact.
//        Then stream a new frame of all 0s -> every word=0x0000.
//   5 abort together with a transfer at pixel_count=100
//     -> pixel dropped; next clk pixel_count=0, frame_ready=0.
//        frame_consume pulse in LOAD -> no change.
//   6 rst asserted at pixel_count=500
//     -> outputs return to reset values asynchronously, before the next clk edge.
//        A full frame loads cleanly after rst is released.

Source files
------------

// File: rtl/gan_pkg.sv
// Shared GAN definitions: Q8.8 pixel words, frame size and the loader state encoding.
package gan_pkg;

    localparam logic [15:0] Q88_ONE         = 16'h0100;
    localparam logic [15:0] Q88_ZERO        = 16'h0000;
    localparam int          GAN_PIXEL_COUNT = 784;

    // LOAD collects incoming pixels, FULL holds a complete frame for the consumer.
    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } loader_state_t;

endpackage

// File: rtl/serial_pixel_loader_if.sv
// Bit-serial pixel stream: one pixel bit per accepted valid/ready handshake.
interface serial_pixel_loader_if;

    logic pixel_bit;
    logic pixel_bit_valid;
    logic pixel_bit_ready;

    // The streamer drives the bit and valid and watches ready.
    modport master (
        output pixel_bit,
        output pixel_bit_valid,
        input  pixel_bit_ready
    );

    // The loader samples the bit and valid and decides ready.
    modport slave (
        input  pixel_bit,
        input  pixel_bit_valid,
        output pixel_bit_ready
    );

endinterface

// File: rtl/serial_pixel_loader.sv
// Receive end of the GAN bit-serial pixel interface. Each accepted bit is expanded to
// a Q8.8 word and stored at the next frame index; once the last pixel lands the frame
// is held and frame_ready stays high until the consumer pulses frame_consume.
module serial_pixel_loader
    import gan_pkg::*;
#(
    parameter int          PIXEL_COUNT = GAN_PIXEL_COUNT,
    parameter logic [15:0] ONE_WORD    = Q88_ONE,
    parameter logic [15:0] ZERO_WORD   = Q88_ZERO,
    localparam int         CW          = $clog2(PIXEL_COUNT + 1),
    localparam int         IW          = $clog2(16 * PIXEL_COUNT)
) (
    input  logic                      clk,
    input  logic                      rst,
    serial_pixel_loader_if.slave      pix,
    input  logic                      frame_consume,
    input  logic                      abort,
    output logic                      frame_ready,
    output logic [16*PIXEL_COUNT-1:0] frame_flat,
    output logic [CW-1:0]             pixel_count,
    output logic [CW-1:0]             ones_count
);

    loader_state_t state;
    loader_state_t state_next;
    logic [CW-1:0] pixel_count_next;
    logic [CW-1:0] ones_count_next;
    logic          transfer;
    logic          write_en;
    logic [15:0]   write_word;
    logic [IW-1:0] write_base;

    // Ready comes from the state alone so the streamer may raise valid at any time.
    assign pix.pixel_bit_ready = (state == LOAD) && !rst;
    assign transfer            = pix.pixel_bit_valid && pix.pixel_bit_ready;
    assign frame_ready         = (state == FULL);
    assign write_word          = pix.pixel_bit ? ONE_WORD : ZERO_WORD;
    assign write_base          = IW'({pixel_count, 4'b0000});

    // Next-state and counter decode; abort overrides both a transfer and a consume.
    always_comb begin
        state_next       = state;
        pixel_count_next = pixel_count;
        ones_count_next  = ones_count;
        write_en         = 1'b0;
        if (abort) begin
            state_next       = LOAD;
            pixel_count_next = '0;
            ones_count_next  = '0;
        end else begin
            case (state)
                LOAD: begin
                    if (transfer) begin
                        write_en         = 1'b1;
                        pixel_count_next = pixel_count + CW'(1);
                        ones_count_next  = ones_count + CW'(pix.pixel_bit);
                        if (pixel_count == CW'(PIXEL_COUNT - 1)) begin
                            state_next = FULL;
                        end
                    end
                end
                FULL: begin
                    if (frame_consume) begin
                        state_next       = LOAD;
                        pixel_count_next = '0;
                        ones_count_next  = '0;
                    end
                end
                default: begin
                    state_next       = LOAD;
                    pixel_count_next = '0;
                    ones_count_next  = '0;
                end
            endcase
        end
    end

    // State and counters; reset drops any partial frame immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            pixel_count <= '0;
            ones_count  <= '0;
        end else begin
            state       <= state_next;
            pixel_count <= pixel_count_next;
            ones_count  <= ones_count_next;
        end
    end

    // Frame storage; only an accepted pixel writes, and only at the current index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_flat <= '0;
        end else if (write_en) begin
            frame_flat[write_base +: 16] <= write_word;
        end
    end

endmodule

// File: tb/tb_serial_pixel_loader.sv
// Directed bench for serial_pixel_loader: full frames, FULL hold, gapped stream,
// consume, abort, consume-in-LOAD and asynchronous reset mid-frame.
module tb_serial_pixel_loader;

    localparam int N  = 784;
    localparam int CW = 10;

    logic            clk;
    logic            rst;
    logic            frame_consume;
    logic            abort;
    logic            frame_ready;
    logic [16*N-1:0] frame_flat;
    logic [CW-1:0]   pixel_count;
    logic [CW-1:0]   ones_count;

    logic [16*N-1:0] exp_flat;
    int              exp_idx;
    int              checks;
    int              failures;

    serial_pixel_loader_if pix ();

    serial_pixel_loader dut (
        .clk           (clk),
        .rst           (rst),
        .pix           (pix.slave),
        .frame_consume (frame_consume),
        .abort         (abort),
        .frame_ready   (frame_ready),
        .frame_flat    (frame_flat),
        .pixel_count   (pixel_count),
        .ones_count    (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_frame(input string tag);
        int bad;
        bad = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (frame_flat[16*i +: 16] !== exp_flat[16*i +: 16]) bad = i;
        end
        checks++;
        assert (frame_flat === exp_flat)
        else begin
            failures++;
            $error("[TB] FAIL %s word=%0d observed=0x%0h expected=0x%0h", tag, bad,
                   (bad >= 0) ? frame_flat[16*bad +: 16] : 16'h0,
                   (bad >= 0) ? exp_flat[16*bad +: 16] : 16'h0);
        end
    endtask

    // Drive one cycle of inputs, then step to 1 time unit past the next rising edge.
    task automatic apply_stimulus(input logic v, input logic b, input logic c, input logic a);
        pix.pixel_bit_valid = v;
        pix.pixel_bit       = b;
        frame_consume       = c;
        abort               = a;
        @(posedge clk);
        #1;
        pix.pixel_bit_valid = 1'b0;
        frame_consume       = 1'b0;
        abort               = 1'b0;
    endtask

    // One pixel the bench expects to be accepted, recorded in the expected frame.
    task automatic push_pixel(input logic b);
        apply_stimulus(1'b1, b, 1'b0, 1'b0);
        exp_flat[16*exp_idx +: 16] = b ? 16'h0100 : 16'h0000;
        exp_idx++;
    endtask

    initial begin
        int sent;
        int cycles;
        logic v;
        checks   = 0;
        failures = 0;
        exp_flat = '0;
        exp_idx  = 0;
        rst                 = 1'b1;
        pix.pixel_bit       = 1'b0;
        pix.pixel_bit_valid = 1'b1;
        frame_consume       = 1'b0;
        abort               = 1'b0;

        // Reset state, with valid already high
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_ready", 32'(pix.pixel_bit_ready), 32'd0);
        check_output("rst_frame_ready", 32'(frame_ready), 32'd0);
        check_output("rst_pixel_count", 32'(pixel_count), 32'd0);
        check_output("rst_ones_count", 32'(ones_count), 32'd0);
        check_frame("rst_frame");
        pix.pixel_bit_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("idle_ready", 32'(pix.pixel_bit_ready), 32'd1);

        // Test 1: alternating 1,0,... for a full frame
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                check_output("t1_not_ready_before_last", 32'(frame_ready), 32'd0);
                check_output("t1_count_before_last", 32'(pixel_count), 32'd783);
            end
            push_pixel((i % 2) == 0);
        end
        check_output("t1_frame_ready", 32'(frame_ready), 32'd1);
        check_output("t1_ready_low", 32'(pix.pixel_bit_ready), 32'd0);
        check_output("t1_pixel_count", 32'(pixel_count), 32'd784);
        check_output("t1_ones_count", 32'(ones_count), 32'd392);
        check_output("t1_word0", 32'(frame_flat[15:0]), 32'h0100);
        check_output("t1_word1", 32'(frame_flat[31:16]), 32'h0000);
        check_frame("t1_frame");

        // Test 2: FULL ignores valid
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
            check_output("t2_ready_low", 32'(pix.pixel_bit_ready), 32'd0);
        end
        check_output("t2_frame_ready", 32'(frame_ready), 32'd1);
        check_output("t2_pixel_count", 32'(pixel_count), 32'd784);
        check_output("t2_ones_count", 32'(ones_count), 32'd392);
        check_frame("t2_frame");

        // Consume: counters clear, old frame kept
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        exp_idx = 0;
        check_output("c1_frame_ready", 32'(frame_ready), 32'd0);
        check_output("c1_ready", 32'(pix.pixel_bit_ready), 32'd1);
        check_output("c1_pixel_count", 32'(pixel_count), 32'd0);
        check_output("c1_ones_count", 32'(ones_count), 32'd0);
        check_frame("c1_frame_kept");

        // Test 3: all ones with random idle gaps
        sent   = 0;
        cycles = 0;
        while (sent < N && cycles < 5000) begin
            v = ($urandom_range(0, 99) >= 30);
            if (v) begin
                push_pixel(1'b1);
                sent++;
            end else begin
                apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
            end
            cycles++;
        end
        check_output("t3_sent_in_budget", 32'(sent), 32'd784);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check_output("t3_frame_ready", 32'(frame_ready), 32'd1);
        check_output("t3_pixel_count", 32'(pixel_count), 32'd784);
        check_output("t3_ones_count", 32'(ones_count), 32'd784);
        check_frame("t3_frame");

        // Test 4: consume, then a frame of all zeros
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        exp_idx = 0;
        check_output("t4_frame_ready", 32'(frame_ready), 32'd0);
        check_output("t4_ready", 32'(pix.pixel_bit_ready), 32'd1);
        check_output("t4_pixel_count", 32'(pixel_count), 32'd0);
        check_frame("t4_frame_kept");
        for (int i = 0; i < N; i++) push_pixel(1'b0);
        check_output("t4_full", 32'(frame_ready), 32'd1);
        check_output("t4_ones_count", 32'(ones_count), 32'd0);
        check_frame("t4_zero_frame");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        exp_idx = 0;

        // Test 5: abort together with a transfer at index 100
        for (int i = 0; i < 100; i++) push_pixel((i % 3) == 0);
        check_output("t5_count_100", 32'(pixel_count), 32'd100);
        check_output("t5_ones_34", 32'(ones_count), 32'd34);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
        exp_idx = 0;
        check_output("t5_abort_count", 32'(pixel_count), 32'd0);
        check_output("t5_abort_ones", 32'(ones_count), 32'd0);
        check_output("t5_abort_frame_ready", 32'(frame_ready), 32'd0);
        check_output("t5_word100_dropped", 32'(frame_flat[16*100 +: 16]), 32'h0000);
        check_frame("t5_frame");
        for (int i = 0; i < 5; i++) push_pixel(1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_output("t5_consume_load_count", 32'(pixel_count), 32'd5);
        check_output("t5_consume_load_ones", 32'(ones_count), 32'd5);
        check_output("t5_consume_load_ready", 32'(pix.pixel_bit_ready), 32'd1);
        check_frame("t5_consume_load_frame");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        exp_idx = 0;
        check_output("t5_clear_count", 32'(pixel_count), 32'd0);

        // Test 6: asynchronous reset at pixel_count 500
        for (int i = 0; i < 500; i++) push_pixel(1'b1);
        check_output("t6_count_500", 32'(pixel_count), 32'd500);
        #3;
        rst = 1'b1;
        #1;
        exp_flat = '0;
        exp_idx  = 0;
        check_output("t6_async_count", 32'(pixel_count), 32'd0);
        check_output("t6_async_ones", 32'(ones_count), 32'd0);
        check_output("t6_async_ready", 32'(pix.pixel_bit_ready), 32'd0);
        check_output("t6_async_frame_ready", 32'(frame_ready), 32'd0);
        check_frame("t6_async_frame");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) push_pixel((i % 5) == 0);
        check_output("t6_reload_ready", 32'(frame_ready), 32'd1);
        check_output("t6_reload_count", 32'(pixel_count), 32'd784);
        check_output("t6_reload_ones", 32'(ones_count), 32'd157);
        check_frame("t6_reload_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
